// File: rtl/sys1_clk_pkg.sv
// rtl/sys1_clk_pkg.sv - shared types and defaults for the System 1 reset/clock-enable block
// Purpose: state encoding for the lock-qualification FSM and default divider constants.
// Ports: none (package).
package sys1_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } sys1_state_t;

  // 93.068170 MHz / 6.5 = 14.318180 MHz, so two 14M enables per 13 clk_sys cycles
  localparam int DEF_DIV_PERIOD = 13;
  localparam int DEF_HALF_PHASE = 7;
  localparam int DEF_CPU_DIV    = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sys1_sync_bit.sv
// rtl/sys1_sync_bit.sv - multi-flop synchronizer for a single asynchronous bit
// Purpose: brings an asynchronous level into the clk domain with STAGES cycles of latency.
// Ports:
//   clk  in  1  destination clock
//   rst  in  1  synchronous active-high reset, clears the chain to 0
//   d    in  1  asynchronous input level
//   q    out 1  synchronized level (last chain stage)
module sys1_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sys1_reset_cen_gen.sv
// rtl/sys1_reset_cen_gen.sv - PLL-lock qualified core reset and 14M/7M/1.79M clock enables
// Purpose: qualifies pll_locked, holds core_reset for RESET_HOLD cycles after lock is stable,
//   then derives all System 1 clock enables from one phase counter on clk_sys.
// Ports:
//   clk_sys     in   1  93.068 MHz clock
//   rst         in   1  synchronous active-high reset
//   pll_locked  in   1  PLL lock flag, asynchronous to clk_sys
//   cen_hold    in   1  pause request; gates enables without disturbing phase
//   core_reset  out  1  synchronous active-high reset to the core
//   cen_14m     out  1  14.318 MHz enable
//   cen_7m      out  1  7.159 MHz enable, phase 0
//   cen_7m_b    out  1  7.159 MHz enable, phase HALF_PHASE
//   cen_1m79    out  1  1.79 MHz enable, on every CPU_DIV-th cen_7m
//   running     out  1  high while in RUN
//   lock_drops  out  8  saturating count of lock losses seen in RUN
module sys1_reset_cen_gen
  import sys1_clk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int RESET_HOLD  = 4096,
  parameter int DIV_PERIOD  = DEF_DIV_PERIOD,
  parameter int HALF_PHASE  = DEF_HALF_PHASE,
  parameter int CPU_DIV     = DEF_CPU_DIV
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       cen_hold,
  output logic       core_reset,
  output logic       cen_14m,
  output logic       cen_7m,
  output logic       cen_7m_b,
  output logic       cen_1m79,
  output logic       running,
  output logic [7:0] lock_drops
);

  localparam int CNT_RAW = $clog2(max_int(LOCK_STABLE, RESET_HOLD));
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int CPU_W   = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [3:0]       PH_LAST   = 4'(DIV_PERIOD - 1);
  localparam logic [3:0]       PH_HALF   = 4'(HALF_PHASE);
  localparam logic [CPU_W-1:0] CPU_LAST  = CPU_W'(CPU_DIV - 1);

  logic lk;

  sys1_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(clk_sys),
    .rst(rst),
    .d  (pll_locked),
    .q  (lk)
  );

  sys1_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ph_q, ph_d;
  logic [CPU_W-1:0] cpu_q, cpu_d;
  logic [7:0]       drops_q, drops_d;
  logic             hold_q;
  logic             en;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      ph_q    <= '0;
      cpu_q   <= '0;
      drops_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      cpu_q   <= cpu_d;
      drops_q <= drops_d;
      hold_q  <= cen_hold;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drops_d = drops_q;
    ph_d    = '0;
    cpu_d   = '0;

    case (state_q)
      WAIT_LOCK: begin
        if (!lk) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          if (drops_q != 8'hFF) begin
            drops_d = drops_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Phase and CPU divider only advance while staying in RUN, so they are zero in
    // the first RUN cycle and return to zero the moment RUN is left.
    if (state_q == RUN && state_d == RUN) begin
      ph_d  = (ph_q == PH_LAST) ? 4'd0 : ph_q + 4'd1;
      cpu_d = cpu_q;
      if (ph_q == 4'd0) begin
        cpu_d = (cpu_q == CPU_LAST) ? '0 : cpu_q + 1'b1;
      end
    end
  end

  // Outputs decode registered state only; cen_hold acts through hold_q, never directly.
  assign running    = (state_q == RUN);
  assign core_reset = ~running;
  assign en         = running & ~hold_q;
  assign cen_7m     = en & (ph_q == 4'd0);
  assign cen_7m_b   = en & (ph_q == PH_HALF);
  assign cen_14m    = cen_7m | cen_7m_b;
  assign cen_1m79   = cen_7m & (cpu_q == '0);
  assign lock_drops = drops_q;

endmodule
